uart_tx_cfg: RTL
================

Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter and successor to the fixed 8N1 transmitter. It serialises one word per frame, LSB first, with a configurable data length of 5-8 bits, parity of none, even or odd, and 1 or 2 stop bits. It sits between the Tx FIFO and the tx pin and is paced by the shared baud-rate generator's sample_tick. The tx_start/tx_done handshake is unchanged, so it drops in where the old transmitter was.

Parameters:
DBITS, 8, width of data_in and maximum data length; must be >= 5.
SB_TICK, 16, sample ticks per bit (oversampling); must be >= 2.

Ports:
clk_100MHz  input  1  system clock (100 MHz board clock)
reset_n  input  1  asynchronous, active-low reset
tx_start  input  1  request to send; high when the Tx FIFO is not empty
sample_tick  input  1  one-cycle strobe from the baud generator, SB_TICK per bit
data_in  input  DBITS  word to transmit; sampled on frame acceptance
cfg_len  input  2  data length: 00=5, 01=6, 10=7, 11=8; a length above DBITS clamps to DBITS
cfg_parity  input  2  00=none, 01=even, 10=odd, 11=none (reserved)
cfg_stop2  input  1  0=one stop bit, 1=two stop bits
tx_done  output  1  one-cycle pulse at the end of the last stop bit; pops the FIFO
busy  output  1  high from frame acceptance until the frame ends
tx  output  1  serial line, registered

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; tx=1, busy=0, tx_done=0; all counters and shadow registers cleared.
  - Reset mid-frame aborts the frame immediately: tx returns high asynchronously and no tx_done is issued.
- States: IDLE -> START -> DATA -> PARITY (skipped when parity is none) -> STOP -> IDLE.
- Acceptance:
  - In IDLE, a cycle with tx_start=1 captures data_in, cfg_len, cfg_parity and cfg_stop2 into shadow registers and moves to START.
  - Config or data changes after acceptance have no effect on the frame in flight.
- Latency: tx drops to 0 on the first clock edge after the accepting cycle. busy rises on the same edge.
- Bit timing:
  - A tick counter of width $clog2(SB_TICK) advances only on sample_tick.
  - A bit ends on the sample_tick where the counter equals SB_TICK-1; the counter then clears.
  - START lasts SB_TICK ticks.
- DATA:
  - tx = shift_reg[0]; the shift register shifts right at the end of each bit.
  - A bit counter of width $clog2(DBITS) counts 0..len-1, then the FSM moves to PARITY or STOP.
- PARITY:
  - The parity bit is the XOR of the len captured data bits only; upper bits are masked.
  - Even: tx = XOR. Odd: tx = ~XOR. Lasts SB_TICK ticks.
- STOP:
  - tx=1 for SB_TICK ticks (one stop bit) or 2*SB_TICK ticks (two stop bits).
  - On the final tick, tx_done=1 for that one cycle (combinational, as before); state returns to IDLE on the same edge.
- busy: falls on the edge where the state returns to IDLE.
- Back-to-back frames:
  - If tx_start is high in the first IDLE cycle, the next frame is accepted immediately.
  - The inter-frame gap is one clock of idle-high in addition to the stop bit(s).
- tx_start while not in IDLE is ignored; there is no queuing.
- sample_tick while in IDLE is ignored; the counters hold at 0.
- Frame length in ticks: SB_TICK * (1 + len + parity_en + stop_bits).

Decomposition:
- Package uart_pkg holds:
  - state encoding (3-bit: IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a len-decode function (cfg_len -> 5..8, clamped to DBITS);
  - a masked-parity function.
- No sub-module needed. The baud generator stays a separate existing block, instantiated by the top level.

Test Plan:
1. 8N1: cfg_len=11, cfg_parity=00, cfg_stop2=0, data_in=0xA5 -> tx bits per SB_TICK: 0,1,0,1,0,0,1,0,1,1; 160 ticks total; one tx_done pulse; busy high throughout.
2. 7E1: cfg_len=10, cfg_parity=01, data_in=0xC1 -> data 1,0,0,0,0,0,1, parity 0 (bit 7 masked), stop 1; 160 ticks.
3. 5O2: cfg_len=00, cfg_parity=10, cfg_stop2=1, data_in=0xFF -> 0,1,1,1,1,1,0,1,1; 144 ticks; tx_done only at the end of the second stop bit.
4. Back-to-back: tx_start held high, data 0x55 then 0x0F (8N1) -> two frames separated by exactly one clock of idle-high; two tx_done pulses; second frame carries 0x0F.
5. Mid-frame changes: change data_in and all cfg_* inputs during DATA -> the frame in flight matches the originally captured values bit-for-bit.
6. Reset mid-frame: assert reset_n=0 during bit 3 of DATA -> tx=1 and busy=0 immediately with no tx_done; after release, a fresh 8N1 frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and frame-config helpers
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   function automatic logic [3:0] decode_len(input logic [1:0] cfg_len, input int dbits);
      int l;
      l = 5 + int'(cfg_len);
      return (l > dbits) ? 4'(dbits) : 4'(l);
   endfunction

   function automatic logic masked_parity(input logic [7:0] data, input logic [3:0] len);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++)
         if (i < int'(len)) p ^= data[i];
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (5-8 data bits, none/even/odd parity, 1/2 stop bits)
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DBITS   = 8,
   parameter int SB_TICK = 16
) (
   input  logic             clk_100MHz,
   input  logic             reset_n,
   input  logic             tx_start,
   input  logic             sample_tick,
   input  logic [DBITS-1:0] data_in,
   input  logic [1:0]       cfg_len,
   input  logic [1:0]       cfg_parity,
   input  logic             cfg_stop2,
   output logic             tx_done,
   output logic             busy,
   output logic             tx
);

   localparam int TW = $clog2(SB_TICK);
   localparam int BW = $clog2(DBITS);

   state_t           state, state_n;
   logic [TW-1:0]    tick, tick_n;
   logic [BW-1:0]    bit_cnt, bit_n;
   logic [DBITS-1:0] shift, shift_n;
   logic [3:0]       len_q;
   logic             par_en, par_val, stop2, stop_sec, stop_sec_n;
   logic             tx_q, tx_n, tick_end, last_bit;

   assign tick_end = sample_tick && (tick == TW'(SB_TICK - 1));
   assign last_bit = bit_cnt == BW'(len_q - 4'd1);
   assign busy     = state != IDLE;
   assign tx       = tx_q;

   always_comb begin
      state_n    = state;
      tick_n     = tick;
      bit_n      = bit_cnt;
      shift_n    = shift;
      stop_sec_n = stop_sec;
      tx_done    = 1'b0;
      if (state != IDLE && sample_tick) tick_n = tick_end ? '0 : tick + TW'(1);
      case (state)
         IDLE:   state_n = tx_start ? START : IDLE;
         START:  state_n = tick_end ? DATA : START;
         DATA: if (tick_end) begin
            shift_n = shift >> 1;
            bit_n   = last_bit ? '0 : bit_cnt + BW'(1);
            state_n = last_bit ? (par_en ? PARITY : STOP) : DATA;
         end
         PARITY: state_n = tick_end ? STOP : PARITY;
         STOP: if (tick_end) begin
            tx_done    = !stop2 || stop_sec;
            stop_sec_n = !tx_done;
            state_n    = tx_done ? IDLE : STOP;
         end
         default: state_n = IDLE;
      endcase
      // tx is registered, so it is derived from the state being entered
      tx_n = (state_n == START)  ? 1'b0 :
             (state_n == DATA)   ? shift_n[0] :
             (state_n == PARITY) ? par_val : 1'b1;
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         tick     <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         len_q    <= '0;
         par_en   <= 1'b0;
         par_val  <= 1'b0;
         stop2    <= 1'b0;
         stop_sec <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_n;
         tick     <= tick_n;
         bit_cnt  <= bit_n;
         stop_sec <= stop_sec_n;
         tx_q     <= tx_n;
         if (state == IDLE && tx_start) begin
            shift   <= data_in;
            len_q   <= decode_len(cfg_len, DBITS);
            par_en  <= cfg_parity inside {PAR_EVEN, PAR_ODD};
            par_val <= (cfg_parity == PAR_ODD) ^ masked_parity(8'(data_in), decode_len(cfg_len, DBITS));
            stop2   <= cfg_stop2;
         end else begin
            shift <= shift_n;
         end
      end
   end

endmodule
